// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and forwarding controller for a five-stage pipeline
// (fetch, decode, execute, memory, write-back). It sits beside decode.
//
// The controller keeps a scoreboard of in-flight destination registers,
// with one entry per stage beyond decode. Entry 0 is EX and entry
// DEPTH-1 is WB. From that scoreboard it drives the forwarding selects
// for both ALU operands. It stalls on load-use hazards, flushes on a
// taken branch, and freezes when the memory side is busy.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   id_valid                   decode holds a valid instruction
//   id_src1/2, id_src1/2_used  source registers and their use flags
//   id_dst, id_wr, id_is_load  destination, write enable, load flag
//   ex_branch_taken            branch in EX resolved taken
//   stall_ext                  memory busy, freeze whole pipeline
//   stall_fd                   hold PC and FD register
//   bubble_de                  load NOP into DE register
//   flush_fd, flush_de         clear FD / DE register
//   fwd_sel1/2                 0 = register file, k+1 = scoreboard entry k
//   stall_cnt                  saturating count of load-use stall cycles
module pipe_hazard_ctrl #(
   parameter int REG_AW     = 3,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 1,
   parameter int SEL_W      = 2,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_src1,
   input  logic              id_src1_used,
   input  logic [REG_AW-1:0] id_src2,
   input  logic              id_src2_used,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_wr,
   input  logic              id_is_load,
   input  logic              ex_branch_taken,
   input  logic              stall_ext,
   output logic              stall_fd,
   output logic              bubble_de,
   output logic              flush_fd,
   output logic              flush_de,
   output logic [SEL_W-1:0]  fwd_sel1,
   output logic [SEL_W-1:0]  fwd_sel2,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [DEPTH-1:0]  r_v;
   logic [DEPTH-1:0]  r_ld;
   logic [REG_AW-1:0] r_dst [DEPTH];
   logic [CNT_W-1:0]  r_stall_cnt;

   logic [DEPTH-1:0]  w_match1;
   logic [DEPTH-1:0]  w_match2;
   logic [SEL_W-1:0]  w_sel1;
   logic [SEL_W-1:0]  w_sel2;
   logic              w_lu;
   logic              w_lu_stall;

   always_comb begin
      w_match1 = '0;
      w_match2 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_match1[k] = r_v[k] & (r_dst[k] == id_src1) & id_src1_used & id_valid;
         w_match2[k] = r_v[k] & (r_dst[k] == id_src2) & id_src2_used & id_valid;
      end
   end

   // Scan from the oldest entry down so that the youngest producer
   // (smallest index) is the last one written and therefore wins.
   always_comb begin
      w_sel1 = '0;
      w_sel2 = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (w_match1[k]) w_sel1 = SEL_W'(k + 1);
         if (w_match2[k]) w_sel2 = SEL_W'(k + 1);
      end
   end

   // A load whose data is not yet forwardable blocks the consumer.
   // The stall ends on its own: the inserted bubble moves the load
   // one entry further down each cycle.
   always_comb begin
      w_lu = 1'b0;
      for (int k = 0; k < LOAD_STAGE && k < DEPTH; k++) begin
         if ((w_match1[k] | w_match2[k]) & r_ld[k]) w_lu = 1'b1;
      end
   end

   assign w_lu_stall = w_lu & ~stall_ext & ~ex_branch_taken;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v         <= '0;
         r_ld        <= '0;
         r_stall_cnt <= '0;
         for (int k = 0; k < DEPTH; k++) r_dst[k] <= '0;
      end else if (!stall_ext) begin
         for (int k = 1; k < DEPTH; k++) begin
            r_v[k]   <= r_v[k-1];
            r_ld[k]  <= r_ld[k-1];
            r_dst[k] <= r_dst[k-1];
         end
         r_v[0]   <= id_valid & id_wr & ~w_lu & ~ex_branch_taken;
         r_ld[0]  <= id_is_load;
         r_dst[0] <= id_dst;
         if (w_lu_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   // Reset masks every output directly, so the outputs drop even while
   // stall_ext or a branch is still being presented.
   assign stall_fd  = ~reset & (stall_ext | w_lu_stall);
   assign bubble_de = ~reset & w_lu_stall;
   assign flush_fd  = ~reset & ~stall_ext & ex_branch_taken;
   assign flush_de  = ~reset & ~stall_ext & ex_branch_taken;
   assign fwd_sel1  = reset ? '0 : w_sel1;
   assign fwd_sel2  = reset ? '0 : w_sel2;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_src1_used, id_src2_used, id_wr, id_is_load;
   logic [2:0] id_src1, id_src2, id_dst;
   logic       ex_branch_taken, stall_ext;

   logic        stall_fd, bubble_de, flush_fd, flush_de;
   logic [1:0]  fwd_sel1, fwd_sel2;
   logic [15:0] stall_cnt;

   logic        c2_stall_fd, c2_bubble_de, c2_flush_fd, c2_flush_de;
   logic [1:0]  c2_fwd_sel1, c2_fwd_sel2;
   logic [1:0]  c2_stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_src1(id_src1), .id_src1_used(id_src1_used),
      .id_src2(id_src2), .id_src2_used(id_src2_used),
      .id_dst(id_dst), .id_wr(id_wr), .id_is_load(id_is_load),
      .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
      .stall_fd(stall_fd), .bubble_de(bubble_de),
      .flush_fd(flush_fd), .flush_de(flush_de),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(2)) dut_c2 (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_src1(id_src1), .id_src1_used(id_src1_used),
      .id_src2(id_src2), .id_src2_used(id_src2_used),
      .id_dst(id_dst), .id_wr(id_wr), .id_is_load(id_is_load),
      .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
      .stall_fd(c2_stall_fd), .bubble_de(c2_bubble_de),
      .flush_fd(c2_flush_fd), .flush_de(c2_flush_de),
      .fwd_sel1(c2_fwd_sel1), .fwd_sel2(c2_fwd_sel2), .stall_cnt(c2_stall_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int sfd, input int bde,
                             input int ffd, input int fde, input int f1, input int f2);
      check_eq({tag, ".stall_fd"},  32'(stall_fd),  sfd);
      check_eq({tag, ".bubble_de"}, 32'(bubble_de), bde);
      check_eq({tag, ".flush_fd"},  32'(flush_fd),  ffd);
      check_eq({tag, ".flush_de"},  32'(flush_de),  fde);
      check_eq({tag, ".fwd_sel1"},  32'(fwd_sel1),  f1);
      check_eq({tag, ".fwd_sel2"},  32'(fwd_sel2),  f2);
   endtask

   task automatic set_id(input logic v, input logic [2:0] s1, input logic s1u,
                         input logic [2:0] s2, input logic s2u,
                         input logic [2:0] d, input logic wr, input logic ld);
      id_valid = v;  id_src1 = s1; id_src1_used = s1u;
      id_src2 = s2;  id_src2_used = s2u;
      id_dst = d;    id_wr = wr;   id_is_load = ld;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      ex_branch_taken = 1'b0;
      stall_ext = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      reset = 1'b1;
      ex_branch_taken = 1'b0;
      stall_ext = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check_outs("reset", 0, 0, 0, 0, 0, 0);
      check_eq("reset.cnt", 32'(stall_cnt), 0);
      repeat (2) step();
      reset = 1'b0;

      // 1: ALU forwarding from EX, MEM and WB, then out of the window
      set_id(1, 0, 0, 0, 0, 1, 1, 0);          // ADD R1
      #1 check_outs("t1.add", 0, 0, 0, 0, 0, 0);
      step();
      set_id(1, 1, 1, 0, 0, 0, 0, 0);          // reads R1, no write
      #1 check_outs("t1.ex", 0, 0, 0, 0, 1, 0);
      step();
      #1 check_outs("t1.mem", 0, 0, 0, 0, 2, 0);
      step();
      #1 check_outs("t1.wb", 0, 0, 0, 0, 3, 0);
      step();
      #1 check_outs("t1.gone", 0, 0, 0, 0, 0, 0);
      step();

      // 2: load-use stall of exactly one cycle
      set_id(1, 0, 0, 0, 0, 2, 1, 1);          // LOAD R2
      #1 check_outs("t2.load", 0, 0, 0, 0, 0, 0);
      step();
      set_id(1, 0, 0, 2, 1, 5, 1, 0);          // consumer of R2
      #1 check_outs("t2.stall", 1, 1, 0, 0, 0, 1);
      step();
      #1 check_outs("t2.go", 0, 0, 0, 0, 0, 2);
      check_eq("t2.cnt", 32'(stall_cnt), 1);
      check_eq("t2.cnt_c2", 32'(c2_stall_cnt), 1);
      step();
      drain();

      // 3: youngest producer wins, each source resolved independently
      set_id(1, 0, 0, 0, 0, 3, 1, 0); step();
      set_id(1, 0, 0, 0, 0, 6, 1, 0); step();
      set_id(1, 0, 0, 0, 0, 3, 1, 0); step();
      set_id(1, 3, 1, 6, 1, 0, 0, 0);
      #1 check_outs("t3.young", 0, 0, 0, 0, 1, 2);
      step();
      set_id(1, 6, 1, 3, 1, 0, 0, 0);
      #1 check_outs("t3.shift", 0, 0, 0, 0, 3, 2);
      set_id(1, 6, 0, 3, 1, 0, 0, 0);          // src1 not used
      #1 check_outs("t3.unused", 0, 0, 0, 0, 0, 2);
      set_id(0, 6, 1, 3, 1, 0, 0, 0);          // not valid
      #1 check_outs("t3.invalid", 0, 0, 0, 0, 0, 0);
      drain();

      // 4: branch flush overrides load-use
      set_id(1, 0, 0, 0, 0, 2, 1, 1); step();
      set_id(1, 2, 1, 0, 0, 7, 1, 0);
      ex_branch_taken = 1'b1;
      #1 check_outs("t4.flush", 0, 0, 1, 1, 1, 0);
      step();
      check_eq("t4.cnt", 32'(stall_cnt), 1);
      ex_branch_taken = 1'b0;
      set_id(1, 7, 1, 2, 1, 0, 0, 0);
      #1 check_outs("t4.after", 0, 0, 0, 0, 0, 2);
      drain();

      // 5: external freeze holds the scoreboard, ignores branch
      set_id(1, 0, 0, 0, 0, 4, 1, 0); step();
      set_id(1, 4, 1, 0, 0, 1, 1, 0);
      stall_ext = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex_branch_taken = (i == 1);
         #1 check_outs("t5.frozen", 1, 0, 0, 0, 1, 0);
         step();
      end
      stall_ext = 1'b0;
      ex_branch_taken = 1'b0;
      #1 check_outs("t5.release", 0, 0, 0, 0, 1, 0);
      check_eq("t5.cnt", 32'(stall_cnt), 1);
      drain();

      // 6: counter saturation with CNT_W=2, then reset mid-stall
      for (int i = 0; i < 5; i++) begin
         set_id(1, 0, 0, 0, 0, 2, 1, 1); step();
         set_id(1, 2, 1, 0, 0, 0, 0, 0);
         #1 check_eq("t6.stall", 32'(stall_fd), 1);
         step();
         #1 check_eq("t6.nostall", 32'(stall_fd), 0);
         step();
      end
      check_eq("t6.cnt", 32'(stall_cnt), 6);
      check_eq("t6.cnt_c2_sat", 32'(c2_stall_cnt), 3);
      set_id(1, 0, 0, 0, 0, 2, 1, 1); step();
      set_id(1, 2, 1, 0, 0, 0, 0, 0);
      #1 check_eq("t6.pre_rst", 32'(stall_fd), 1);
      stall_ext = 1'b1;
      ex_branch_taken = 1'b1;
      reset = 1'b1;
      #1 check_outs("t6.rst", 0, 0, 0, 0, 0, 0);
      check_eq("t6.rst_cnt", 32'(stall_cnt), 0);
      check_eq("t6.rst_cnt_c2", 32'(c2_stall_cnt), 0);
      check_eq("t6.rst_c2_sfd", 32'(c2_stall_fd), 0);
      step();
      reset = 1'b0;
      stall_ext = 1'b0;
      ex_branch_taken = 1'b0;
      #1 check_outs("t6.empty", 0, 0, 0, 0, 0, 0);
      step();
      check_eq("t6.cnt_after", 32'(stall_cnt), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the five-stage pipeline (fetch, decode, execute, memory, write-back).
- Keeps a scoreboard of in-flight destination registers, one entry per stage beyond decode.
- Drives forwarding selects for both ALU operands.
- Detects load-use hazards and issues stall plus bubble.
- Handles taken-branch flush and an external freeze from the memory side.
- Sits beside the decode stage; its outputs gate the PC, FD and DE pipeline registers and the execute-stage operand muxes.

Parameters:
REG_AW, 3, register address width (8 GPRs)
DEPTH, 3, scoreboard entries; entry 0 = EX, entry DEPTH-1 = WB
LOAD_STAGE, 1, first entry index at which load data can be forwarded; matching loads at index < LOAD_STAGE stall
SEL_W, 2, forwarding select width; must satisfy 2^SEL_W > DEPTH
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
id_valid  in  1  decode holds a valid instruction
id_src1  in  REG_AW  source 1 register number
id_src1_used  in  1  instruction reads src1
id_src2  in  REG_AW  source 2 register number
id_src2_used  in  1  instruction reads src2
id_dst  in  REG_AW  destination register number
id_wr  in  1  instruction writes id_dst
id_is_load  in  1  destination is written from data memory
ex_branch_taken  in  1  branch in EX resolved taken
stall_ext  in  1  memory busy; freeze whole pipeline
stall_fd  out  1  hold PC and FD register
bubble_de  out  1  load NOP into DE register
flush_fd  out  1  clear FD register
flush_de  out  1  clear DE register
fwd_sel1  out  SEL_W  0 = register file, k+1 = scoreboard entry k
fwd_sel2  out  SEL_W  as fwd_sel1, for source 2
stall_cnt  out  CNT_W  load-use stall cycles since reset, saturating

Behaviour:
Scoreboard:
- DEPTH entries, each {v, dst, ld}.
- Reset: all v=0 and stall_cnt=0. Reset asserted forces every output to 0.

Match:
- match_s[k] = v[k] & (dst[k]==id_srcS) & id_srcS_used & id_valid.

Forwarding:
- fwd_selS = k+1 for the smallest k with match_s[k] (youngest producer wins); 0 if no match.
- Combinational, zero latency.

Load-use:
- lu = OR over k<LOAD_STAGE of (match_1[k]|match_2[k]) & ld[k].
- Stall lasts LOAD_STAGE-k cycles for a producer at entry k.

Output priority, highest first:
1. reset: all outputs 0.
2. stall_ext=1: stall_fd=1, bubble_de=0, flush_fd=0, flush_de=0. Scoreboard and stall_cnt hold. ex_branch_taken is ignored.
3. ex_branch_taken=1: flush_fd=1, flush_de=1, stall_fd=0, bubble_de=0. lu is suppressed.
4. lu=1: stall_fd=1, bubble_de=1.
5. Otherwise all 0.

Scoreboard update on clock edge when stall_ext=0:
- Entry k+1 takes entry k.
- Entry 0 takes {1, id_dst, id_is_load} if id_valid & id_wr & !lu & !ex_branch_taken; otherwise v=0 (bubble).
- Entry DEPTH-1 is shifted out after WB.

stall_cnt:
- +1 on each edge where priority-4 stall is active (lu=1, stall_ext=0, ex_branch_taken=0).
- Saturates at 2^CNT_W-1.

Reset:
- Asynchronous reset mid-stall clears the scoreboard and counter immediately.
- First edge after deassertion behaves as an empty pipeline.

Other rules:
- The same register in both sources may match different entries; each select is resolved independently.
- An instruction with id_wr=0 never occupies the scoreboard.

Test Plan:
1. Reset, then ADD R1 (dst=1, wr) and next cycle src1=1 -> fwd_sel1=1, stall_fd=0. One cycle later, with an unrelated instruction in between, src1=1 -> fwd_sel1=2.
2. LOAD R2 (ld=1) followed by src2=2 -> stall_fd=1 and bubble_de=1 for exactly 1 cycle. Then fwd_sel2=2 and stall_cnt=1.
3. Producers R3 at entry 2 and R3 at entry 0, consumer src1=3 -> fwd_sel1=1 (youngest wins).
4. Load-use condition together with ex_branch_taken=1 -> flush_fd=1, flush_de=1, stall_fd=0, stall_cnt unchanged. Next cycle entry 0 v=0.
5. stall_ext=1 for 3 cycles with R4 in entry 0 -> stall_fd=1 and scoreboard frozen. After release, fwd for src=4 still =1.
6. Force CNT_W=2 and 5 load-use stalls -> stall_cnt=3. Assert reset mid-stall -> all outputs 0 asynchronously and stall_cnt=0.
